// File: rtl/conv_pkg.sv
// conv_pkg: shared definitions for the conv_layer engine.
//   state_t  - controller states (S_IDLE, S_CALC, S_EMIT, S_DONE)
//   DEF_*    - default datapath widths
//   out_dim  - output map dimension for a given input size, kernel and stride
package conv_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_EMIT = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_W_W    = 8;
  localparam int DEF_ACC_W  = 24;

  function automatic int out_dim(input int in_sz, input int k, input int stride);
    return (in_sz - k) / stride + 1;
  endfunction

endpackage

// File: rtl/conv_mac.sv
// conv_mac: combinational K_H x K_W window dot product.
// Ports:
//   pix  - K_H*K_W unsigned pixels, element i at pix[i*DATA_W +: DATA_W]
//   wts  - K_H*K_W signed weights,  element i at wts[i*W_W +: W_W]
//   sum  - signed ACC_W sum of products, wrapping modulo 2^ACC_W
module conv_mac import conv_pkg::*; #(
  parameter int K_H    = 3,
  parameter int K_W    = 3,
  parameter int DATA_W = DEF_DATA_W,
  parameter int W_W    = DEF_W_W,
  parameter int ACC_W  = DEF_ACC_W
) (
  input  logic [K_H*K_W*DATA_W-1:0] pix,
  input  logic [K_H*K_W*W_W-1:0]    wts,
  output logic [ACC_W-1:0]          sum
);

  localparam int KN = K_H * K_W;
  localparam int PW = DATA_W + 1 + W_W;

  logic signed [PW-1:0]    prod;
  logic signed [ACC_W-1:0] acc;

  // Pixels get a zero MSB so the multiply is signed x signed; the size cast
  // sign-extends (or truncates) each product into the accumulator width.
  always_comb begin
    acc  = '0;
    prod = '0;
    for (int i = 0; i < KN; i++) begin
      prod = $signed({1'b0, pix[i*DATA_W +: DATA_W]}) * $signed(wts[i*W_W +: W_W]);
      acc  = acc + ACC_W'(prod);
    end
  end

  assign sum = acc;

endmodule

// File: rtl/conv_layer.sv
// conv_layer: multi-input-channel 2-D convolution engine.
// For every output channel / row / col it accumulates the window dot product
// over all input channels (one input channel per cycle through a single
// conv_mac), adds the channel bias and streams the result out.
// Ports:
//   clk, rst         - clock, synchronous active-high reset
//   start            - begin a layer pass (only looked at in S_IDLE)
//   in_map           - flat [IN_CHAN][IN_H][IN_W] unsigned pixels
//   w_conv           - flat [OUT_CHAN][IN_CHAN][K_H][K_W] signed weights
//   bias             - flat [OUT_CHAN] signed biases
//   busy             - pass in progress
//   out_pixel/out_row/out_col/out_chan/out_last - result and sidebands
//   out_valid/out_ready - output handshake
//   done             - one-cycle pulse after the final handshake
//   state_dbg        - current controller state
// Handshake: a transfer happens on a rising edge where out_valid && out_ready;
// while out_valid is high and out_ready low, out_pixel and all sidebands hold.
// out_ready while out_valid is low is ignored.
// Build option: define CONV_LAYER_RELU_EN to clamp negative results to 0.
module conv_layer import conv_pkg::*; #(
  parameter int K_H      = 3,
  parameter int K_W      = 3,
  parameter int IN_H     = 16,
  parameter int IN_W     = 15,
  parameter int IN_CHAN  = 4,
  parameter int OUT_CHAN = 10,
  parameter int STRIDE   = 1,
  parameter int DATA_W   = DEF_DATA_W,
  parameter int W_W      = DEF_W_W,
  parameter int ACC_W    = DEF_ACC_W
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic                                      start,
  input  logic [IN_CHAN*IN_H*IN_W*DATA_W-1:0]       in_map,
  input  logic [OUT_CHAN*IN_CHAN*K_H*K_W*W_W-1:0]   w_conv,
  input  logic [OUT_CHAN*ACC_W-1:0]                 bias,
  output logic                                      busy,
  output logic [ACC_W-1:0]                          out_pixel,
  output logic                                      out_valid,
  input  logic                                      out_ready,
  output logic [7:0]                                out_row,
  output logic [7:0]                                out_col,
  output logic [$clog2(OUT_CHAN)-1:0]               out_chan,
  output logic                                      out_last,
  output logic                                      done,
  output logic [1:0]                                state_dbg
);

  localparam int OUT_H  = out_dim(IN_H, K_H, STRIDE);
  localparam int OUT_W  = out_dim(IN_W, K_W, STRIDE);
  localparam int OC_W   = $clog2(OUT_CHAN);
  localparam int IC_W   = (IN_CHAN > 1) ? $clog2(IN_CHAN) : 1;
  localparam int KN     = K_H * K_W;
  localparam int MAP_IW = $clog2(IN_CHAN*IN_H*IN_W*DATA_W);
  localparam int WT_IW  = $clog2(OUT_CHAN*IN_CHAN*K_H*K_W*W_W);
  localparam int B_IW   = $clog2(OUT_CHAN*ACC_W);

  localparam logic [7:0]      ROW_MAX = 8'(OUT_H - 1);
  localparam logic [7:0]      COL_MAX = 8'(OUT_W - 1);
  localparam logic [OC_W-1:0] OC_MAX  = OC_W'(OUT_CHAN - 1);
  localparam logic [IC_W-1:0] IC_MAX  = IC_W'(IN_CHAN - 1);

  state_t                  state;
  logic [IC_W-1:0]         ic;
  logic [ACC_W-1:0]        acc;

  logic [KN*DATA_W-1:0]    win_pix;
  logic [KN*W_W-1:0]       win_w;
  logic [ACC_W-1:0]        mac_sum;
  logic [ACC_W-1:0]        bias_oc;
  logic [ACC_W-1:0]        acc_base;
  logic [ACC_W-1:0]        acc_sum;
  logic [ACC_W-1:0]        result;
  logic [MAP_IW-1:0]       pix_base;
  logic [WT_IW-1:0]        wt_base;
  logic [B_IW-1:0]         bias_base;
  int                      pi;
  int                      wi;
  logic                    is_last;

  assign state_dbg = state;

  // Gather the window for the current (oc, ic, row, col) from the flat maps.
  always_comb begin
    win_pix  = '0;
    win_w    = '0;
    pi       = 0;
    wi       = 0;
    pix_base = '0;
    wt_base  = '0;
    for (int kr = 0; kr < K_H; kr++) begin
      for (int kc = 0; kc < K_W; kc++) begin
        pi = (int'(ic) * IN_H + int'(out_row) * STRIDE + kr) * IN_W
             + int'(out_col) * STRIDE + kc;
        wi = ((int'(out_chan) * IN_CHAN + int'(ic)) * K_H + kr) * K_W + kc;
        pix_base = MAP_IW'(pi * DATA_W);
        wt_base  = WT_IW'(wi * W_W);
        win_pix[(kr*K_W+kc)*DATA_W +: DATA_W] = in_map[pix_base +: DATA_W];
        win_w[(kr*K_W+kc)*W_W +: W_W]         = w_conv[wt_base +: W_W];
      end
    end
  end

  conv_mac #(
    .K_H    (K_H),
    .K_W    (K_W),
    .DATA_W (DATA_W),
    .W_W    (W_W),
    .ACC_W  (ACC_W)
  ) u_mac (
    .pix (win_pix),
    .wts (win_w),
    .sum (mac_sum)
  );

  assign bias_base = B_IW'(int'(out_chan) * ACC_W);
  assign bias_oc   = bias[bias_base +: ACC_W];

  // The first channel of a pixel starts from the bias instead of a preload
  // cycle, so each pixel costs exactly IN_CHAN compute cycles.
  assign acc_base = (ic == '0) ? bias_oc : acc;
  assign acc_sum  = acc_base + mac_sum;

`ifdef CONV_LAYER_RELU_EN
  assign result = acc_sum[ACC_W-1] ? '0 : acc_sum;
`else
  assign result = acc_sum;
`endif

  assign is_last = (out_chan == OC_MAX) && (out_row == ROW_MAX) && (out_col == COL_MAX);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      ic        <= '0;
      acc       <= '0;
      out_pixel <= '0;
      out_valid <= 1'b0;
      out_row   <= '0;
      out_col   <= '0;
      out_chan  <= '0;
      out_last  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          done <= 1'b0;
          if (start) begin
            state    <= S_CALC;
            busy     <= 1'b1;
            ic       <= '0;
            out_row  <= '0;
            out_col  <= '0;
            out_chan <= '0;
          end
        end
        S_CALC: begin
          if (ic == IC_MAX) begin
            out_pixel <= result;
            out_valid <= 1'b1;
            out_last  <= is_last;
            state     <= S_EMIT;
          end else begin
            acc <= acc_sum;
            ic  <= ic + 1'b1;
          end
        end
        S_EMIT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            // Coordinates advance col fastest, then row, then channel.
            if (out_col == COL_MAX) begin
              out_col <= '0;
              if (out_row == ROW_MAX) begin
                out_row  <= '0;
                out_chan <= (out_chan == OC_MAX) ? '0 : out_chan + 1'b1;
              end else begin
                out_row <= out_row + 8'd1;
              end
            end else begin
              out_col <= out_col + 8'd1;
            end
            if (out_last) begin
              state <= S_DONE;
              done  <= 1'b1;
              busy  <= 1'b0;
            end else begin
              state <= S_CALC;
              ic    <= '0;
            end
          end
        end
        S_DONE: begin
          done  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_conv_layer.sv
// tb_conv_layer: directed bench for conv_layer.
// DUT a uses the default geometry; DUT b is a small stride-2, 16-bit build
// used for the ramp/centre-weight and wrap-around vectors.
module tb_conv_layer;

  // ---------------- DUT a: defaults ----------------
  localparam int A_MAP = 4*16*15*8;
  localparam int A_WT  = 10*4*9*8;
  localparam int A_B   = 10*24;
  localparam int A_N   = 10*14*13;   // 1820 output pixels

  // ---------------- DUT b: small stride-2 ----------------
  localparam int B_MAP = 4*7*7*8;
  localparam int B_WT  = 2*4*9*8;
  localparam int B_B   = 2*16;
  localparam int B_N   = 2*3*3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic             a_start, a_ready, a_busy, a_valid, a_last, a_done;
  logic [A_MAP-1:0] a_map;
  logic [A_WT-1:0]  a_w;
  logic [A_B-1:0]   a_bias;
  logic [23:0]      a_pix;
  logic [7:0]       a_row, a_col;
  logic [3:0]       a_chan;
  logic [1:0]       a_state;

  logic             b_start, b_ready, b_busy, b_valid, b_last, b_done;
  logic [B_MAP-1:0] b_map;
  logic [B_WT-1:0]  b_w;
  logic [B_B-1:0]   b_bias;
  logic [15:0]      b_pix;
  logic [7:0]       b_row, b_col;
  logic [0:0]       b_chan;
  logic [1:0]       b_state;

  conv_layer u_a (
    .clk(clk), .rst(rst), .start(a_start), .in_map(a_map), .w_conv(a_w),
    .bias(a_bias), .busy(a_busy), .out_pixel(a_pix), .out_valid(a_valid),
    .out_ready(a_ready), .out_row(a_row), .out_col(a_col), .out_chan(a_chan),
    .out_last(a_last), .done(a_done), .state_dbg(a_state)
  );

  conv_layer #(
    .K_H(3), .K_W(3), .IN_H(7), .IN_W(7), .IN_CHAN(4), .OUT_CHAN(2),
    .STRIDE(2), .DATA_W(8), .W_W(8), .ACC_W(16)
  ) u_b (
    .clk(clk), .rst(rst), .start(b_start), .in_map(b_map), .w_conv(b_w),
    .bias(b_bias), .busy(b_busy), .out_pixel(b_pix), .out_valid(b_valid),
    .out_ready(b_ready), .out_row(b_row), .out_col(b_col), .out_chan(b_chan),
    .out_last(b_last), .done(b_done), .state_dbg(b_state)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [23:0] exp_q[$];
  logic [19:0] exp_c_q[$];
  logic [15:0] exp_b_q[$];
  logic [16:0] exp_bc_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge. Observes, drives out_ready, advances one cycle.
  task automatic collect_a(input int n_total, input int n_get, input bit rnd,
                           input int poke_at, input bit chk_done);
    int got = 0;
    int cyc = 0;
    bit stalled = 0;
    logic [23:0] sp, ep;
    logic [19:0] sc, ec;
    logic sl;
    while (got < n_get && cyc < 40*n_get + 100) begin
      a_start = (got == poke_at);
      if (a_valid && stalled) begin
        chk("a_stall_pix", a_pix, sp);
        chk("a_stall_coord", {a_chan, a_row, a_col}, sc);
        chk("a_stall_last", a_last, sl);
      end
      a_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (a_valid && a_ready) begin
        ep = exp_q.pop_front();
        ec = exp_c_q.pop_front();
        chk("a_pix", a_pix, ep);
        chk("a_coord", {a_chan, a_row, a_col}, ec);
        chk("a_last", a_last, (got == n_total-1));
        got++;
        stalled = 0;
      end else if (a_valid) begin
        stalled = 1;
        sp = a_pix;
        sc = {a_chan, a_row, a_col};
        sl = a_last;
      end
      cyc++;
      @(negedge clk);
    end
    a_start = 1'b0;
    chk("a_count", got, n_get);
    if (chk_done) begin
      chk("a_done_pulse", a_done, 1);
      chk("a_busy_at_done", a_busy, 0);
      chk("a_valid_at_done", a_valid, 0);
      @(negedge clk);
      chk("a_done_clear", a_done, 0);
      chk("a_idle_after", a_state, 0);
    end
  endtask

  task automatic collect_b(input int n_total);
    int got = 0;
    int cyc = 0;
    logic [15:0] ep;
    logic [16:0] ec;
    b_ready = 1'b1;
    while (got < n_total && cyc < 40*n_total + 100) begin
      if (b_valid) begin
        ep = exp_b_q.pop_front();
        ec = exp_bc_q.pop_front();
        chk("b_pix", b_pix, ep);
        chk("b_coord", {b_chan, b_row, b_col}, ec);
        chk("b_last", b_last, (got == n_total-1));
        got++;
      end
      cyc++;
      @(negedge clk);
    end
    chk("b_count", got, n_total);
    chk("b_done_pulse", b_done, 1);
    chk("b_busy_at_done", b_busy, 0);
  endtask

  task automatic fill_a_exp_const(input logic [23:0] v);
    exp_q.delete();
    exp_c_q.delete();
    for (int oc = 0; oc < 10; oc++)
      for (int r = 0; r < 14; r++)
        for (int c = 0; c < 13; c++) begin
          exp_q.push_back(v);
          exp_c_q.push_back({4'(oc), 8'(r), 8'(c)});
        end
  endtask

  task automatic pulse_start_a();
    a_start = 1'b1;
    @(negedge clk);
    a_start = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int k;
    logic [23:0] bv;
    rst = 1'b1;
    a_start = 0; b_start = 0; a_ready = 1; b_ready = 1;
    a_map = '0; a_w = '0; a_bias = '0;
    b_map = '0; b_w = '0; b_bias = '0;
    repeat (3) @(negedge clk);

    // ---- reset values ----
    chk("rst_valid", a_valid, 0);
    chk("rst_pix", a_pix, 0);
    chk("rst_row", a_row, 0);
    chk("rst_col", a_col, 0);
    chk("rst_chan", a_chan, 0);
    chk("rst_last", a_last, 0);
    chk("rst_busy", a_busy, 0);
    chk("rst_done", a_done, 0);
    chk("rst_state", a_state, 0);
    chk("rst_b_valid", b_valid, 0);
    chk("rst_b_busy", b_busy, 0);
    rst = 1'b0;
    @(negedge clk);

    // ---- run 1: ones everywhere, bias 0, ready high -> 36 each ----
    for (int i = 0; i < A_MAP/8; i++) a_map[i*8 +: 8] = 8'd1;
    for (int i = 0; i < A_WT/8; i++)  a_w[i*8 +: 8]   = 8'd1;
    a_bias = '0;
    fill_a_exp_const(24'd36);
    a_ready = 1'b1;
    a_start = 1'b1;
    @(negedge clk);
    a_start = 1'b0;
    chk("a_busy_after_start", a_busy, 1);
    k = 1;
    while (!a_valid && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk("a_first_valid_lat", k, 5);
    collect_a(A_N, A_N, 1'b0, -1, 1'b1);

    // ---- run 2: zero weights, bias -100+oc, random stalls, start while busy ----
    a_w = '0;
    exp_q.delete();
    exp_c_q.delete();
    for (int oc = 0; oc < 10; oc++) begin
      a_bias[oc*24 +: 24] = 24'(-100 + oc);
`ifdef CONV_LAYER_RELU_EN
      bv = 24'd0;
`else
      bv = 24'(-100 + oc);
`endif
      for (int r = 0; r < 14; r++)
        for (int c = 0; c < 13; c++) begin
          exp_q.push_back(bv);
          exp_c_q.push_back({4'(oc), 8'(r), 8'(c)});
        end
    end
    pulse_start_a();
    collect_a(A_N, A_N, 1'b1, 100, 1'b1);

    // ---- DUT b: ramp image, centre weight oc+1, stride 2 ----
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 7; r++)
        for (int x = 0; x < 7; x++)
          b_map[((c*7 + r)*7 + x)*8 +: 8] = 8'(c*49 + r*7 + x);
    b_w = '0;
    for (int oc = 0; oc < 2; oc++)
      for (int ic = 0; ic < 4; ic++)
        b_w[(((oc*4 + ic)*3 + 1)*3 + 1)*8 +: 8] = 8'(oc + 1);
    b_bias = '0;
    for (int oc = 0; oc < 2; oc++)
      for (int r = 0; r < 3; r++)
        for (int c = 0; c < 3; c++) begin
          exp_b_q.push_back(16'((oc + 1) * (326 + 56*r + 8*c)));
          exp_bc_q.push_back({1'(oc), 8'(r), 8'(c)});
        end
    b_start = 1'b1;
    @(negedge clk);
    b_start = 1'b0;
    collect_b(B_N);
    repeat (2) @(negedge clk);

    // ---- DUT b: 255 x -128 over 36 taps wraps to 16'h1200 ----
    for (int i = 0; i < B_MAP/8; i++) b_map[i*8 +: 8] = 8'hFF;
    for (int i = 0; i < B_WT/8; i++)  b_w[i*8 +: 8]   = 8'h80;
    exp_b_q.delete();
    exp_bc_q.delete();
    for (int oc = 0; oc < 2; oc++)
      for (int r = 0; r < 3; r++)
        for (int c = 0; c < 3; c++) begin
          exp_b_q.push_back(16'h1200);
          exp_bc_q.push_back({1'(oc), 8'(r), 8'(c)});
        end
    b_start = 1'b1;
    @(negedge clk);
    b_start = 1'b0;
    collect_b(B_N);
    repeat (2) @(negedge clk);

    // ---- run 3: reset after 50 pixels, then restart from (0,0,0) ----
    for (int i = 0; i < A_WT/8; i++) a_w[i*8 +: 8] = 8'd1;
    a_bias = '0;
    fill_a_exp_const(24'd36);
    pulse_start_a();
    collect_a(A_N, 50, 1'b0, -1, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_state", a_state, 0);
    chk("midrst_valid", a_valid, 0);
    chk("midrst_busy", a_busy, 0);
    chk("midrst_coord", {a_chan, a_row, a_col}, 0);
    rst = 1'b0;
    @(negedge clk);
    fill_a_exp_const(24'd36);
    pulse_start_a();
    collect_a(A_N, 3, 1'b0, -1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
